// File: rtl/fb_reader.sv
// Frame-buffer read side: fetches the pixel LOOKAHEAD columns ahead of the raster
// from a double-buffered 320x240 RGB444 store and swaps banks only in vertical blank.
module fb_reader #(
   parameter int H_TOTAL   = 800,
   parameter int V_TOTAL   = 525,
   parameter int LOOKAHEAD = 3
) (
   input  logic        pixel_clk,
   input  logic        rst,
   input  logic [9:0]  hcnt,
   input  logic [9:0]  vcnt,
   output logic [16:0] mem_addr,
   output logic        mem_bank,
   output logic        mem_rd_en,
   input  logic [11:0] mem_rdata,
   input  logic        wr_frame_done,
   output logic        swap_ack,
   output logic        frame_dropped,
   output logic [3:0]  vgaInR,
   output logic [3:0]  vgaInG,
   output logic [3:0]  vgaInB
);

   localparam int CW = 12;

   typedef enum logic {
      IDLE,
      PENDING
   } swap_state_t;

   swap_state_t state, state_next;

   logic [CW-1:0] tx_sum, tx, ty_inc, ty;
   logic [16:0]   tx_half, ty_half, addr_next;
   logic          in_range, visible;
   logic [1:0]    vis_d;
   logic          swap_point, do_swap, drop;

   // Target pixel: raster position plus lookahead, wrapped onto the next line/frame.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      in_range = (hcnt < 10'(H_TOTAL)) && (vcnt < 10'(V_TOTAL));
      tx_sum   = CW'(hcnt) + CW'(LOOKAHEAD);
      tx       = tx_sum;
      ty_inc   = CW'(vcnt);
      if (tx_sum >= CW'(H_TOTAL)) begin
         tx     = tx_sum - CW'(H_TOTAL);
         ty_inc = CW'(vcnt) + CW'(1);
      end
      ty        = (ty_inc >= CW'(V_TOTAL)) ? '0 : ty_inc;
      visible   = in_range && (tx < CW'(640)) && (ty < CW'(480));
      tx_half   = 17'(tx >> 1);
      ty_half   = 17'(ty >> 1);
      addr_next = (ty_half << 8) + (ty_half << 6) + tx_half;
   end

   // Address at N, BRAM read at N+1, colour captured at end of N+2.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         mem_addr  <= '0;
         mem_rd_en <= 1'b0;
         vis_d     <= '0;
         vgaInR    <= '0;
         vgaInG    <= '0;
         vgaInB    <= '0;
      end else begin
         mem_rd_en <= visible;
         if (visible) mem_addr <= addr_next;
         vis_d <= {vis_d[0], visible};
         if (vis_d[1]) {vgaInR, vgaInG, vgaInB} <= mem_rdata;
         else          {vgaInR, vgaInG, vgaInB} <= '0;
      end
   end

   assign swap_point = (hcnt == 10'd0) && (vcnt == 10'd480);

   always_comb begin
      state_next = state;
      do_swap    = 1'b0;
      drop       = 1'b0;
      case (state)
         IDLE: begin
            if (wr_frame_done) begin
               if (swap_point) do_swap    = 1'b1;
               else            state_next = PENDING;
            end
         end
         PENDING: begin
            if (swap_point) begin
               do_swap    = 1'b1;
               state_next = IDLE;
            end else if (wr_frame_done) begin
               drop = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         state         <= IDLE;
         mem_bank      <= 1'b0;
         swap_ack      <= 1'b0;
         frame_dropped <= 1'b0;
      end else begin
         state    <= state_next;
         swap_ack <= do_swap;
         if (do_swap) mem_bank      <= ~mem_bank;
         if (drop)    frame_dropped <= 1'b1;
      end
   end

endmodule
